// File: rtl/sdram_pkg.sv
// Purpose : shared types and defaults for the SDRAM scheduler and command engine.
// Latency : n/a (types, constants and one pure helper function).
// Backpressure: n/a.
// Contents: cmd_op encoding, scheduler state encoding, default geometry/timing
//           constants, and the source-priority function used in IDLE.
package sdram_pkg;

    localparam int DEF_ADDR_WIDTH       = 22;   // 4M x16 word address
    localparam int DEF_REFRESH_INTERVAL = 375;  // 7.8 us at 48 MHz
    localparam int DEF_REFRESH_DEBT_MAX = 8;
    localparam int DEF_FORCE_LEVEL      = 4;
    localparam int DEBT_WIDTH           = 4;

    typedef enum logic [1:0] {
        CMD_NONE    = 2'd0,
        CMD_WRITE   = 2'd1,
        CMD_READ    = 2'd2,
        CMD_REFRESH = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } sched_state_e;

    // Source priority: forced refresh, urgent read, round-robin between
    // write and read, lone request, then opportunistic refresh.
    function automatic cmd_op_e pick_source(
        input logic    force_refresh,
        input logic    debt_owed,
        input logic    wr_req,
        input logic    rd_req,
        input logic    rd_urgent,
        input cmd_op_e last_grant
    );
        cmd_op_e sel;
        sel = CMD_NONE;
        if (force_refresh)
            sel = CMD_REFRESH;
        else if (rd_req && rd_urgent)
            sel = CMD_READ;
        else if (wr_req && rd_req)
            sel = (last_grant == CMD_READ) ? CMD_WRITE : CMD_READ;
        else if (wr_req)
            sel = CMD_WRITE;
        else if (rd_req)
            sel = CMD_READ;
        else if (debt_owed)
            sel = CMD_REFRESH;
        return sel;
    endfunction

endpackage

// File: rtl/sdram_request_scheduler_if.sv
// Purpose : requester, command-engine and status signals of the scheduler.
// Latency : n/a (wiring only).
// Backpressure: cmd_ready stalls the command; wr_req/rd_req held until ack.
// Modports: master = scheduler (drives acks, command, status);
//           slave  = environment (requesters plus command engine).
interface sdram_request_scheduler_if #(
    parameter int ADDR_WIDTH = sdram_pkg::DEF_ADDR_WIDTH
);
    logic                            wr_req;
    logic [ADDR_WIDTH-1:0]           wr_addr;
    logic                            wr_ack;
    logic                            rd_req;
    logic [ADDR_WIDTH-1:0]           rd_addr;
    logic                            rd_urgent;
    logic                            rd_ack;
    logic                            cmd_valid;
    sdram_pkg::cmd_op_e              cmd_op;
    logic [ADDR_WIDTH-1:0]           cmd_addr;
    logic                            cmd_ready;
    logic                            cmd_done;
    logic [sdram_pkg::DEBT_WIDTH-1:0] refresh_debt;
    logic                            overrun_err;

    modport master (
        input  wr_req, wr_addr, rd_req, rd_addr, rd_urgent, cmd_ready, cmd_done,
        output wr_ack, rd_ack, cmd_valid, cmd_op, cmd_addr, refresh_debt, overrun_err
    );

    modport slave (
        output wr_req, wr_addr, rd_req, rd_addr, rd_urgent, cmd_ready, cmd_done,
        input  wr_ack, rd_ack, cmd_valid, cmd_op, cmd_addr, refresh_debt, overrun_err
    );
endinterface

// File: rtl/refresh_timer.sv
// Purpose : refresh tick counter, owed-refresh debt counter and sticky overrun flag.
// Latency : debt/overrun update the cycle after a tick or refresh_taken.
// Backpressure: none; debt saturates at REFRESH_DEBT_MAX and flags overrun.
// Ports   : sdram_clk, resetn, refresh_taken (refresh command accepted this cycle),
//           debt (owed refreshes), overrun (sticky until reset).
module refresh_timer
    import sdram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int REFRESH_DEBT_MAX = DEF_REFRESH_DEBT_MAX
) (
    input  logic                  sdram_clk,
    input  logic                  resetn,
    input  logic                  refresh_taken,
    output logic [DEBT_WIDTH-1:0] debt,
    output logic                  overrun
);
    localparam int CNT_W = $clog2(REFRESH_INTERVAL);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [DEBT_WIDTH-1:0] DEBT_MAX = DEBT_WIDTH'(REFRESH_DEBT_MAX);

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = (tick_cnt == CNT_LAST);

    always_ff @(posedge sdram_clk or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
            debt     <= '0;
            overrun  <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            // A tick coinciding with a refresh acceptance cancels out.
            if (tick && !refresh_taken) begin
                if (debt == DEBT_MAX)
                    overrun <= 1'b1;
                else
                    debt <= debt + DEBT_WIDTH'(1);
            end else if (!tick && refresh_taken && debt != '0) begin
                debt <= debt - DEBT_WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/sdram_request_scheduler.sv
// Purpose : arbitrates camera writes, HDMI reads and auto-refresh onto one SDRAM command engine.
// Latency : command presented 1 cycle after the IDLE decision; acks pulse the cycle after acceptance.
// Backpressure: command held stable while cmd_ready is low; one command outstanding until cmd_done.
// Ports   : sdram_clk, resetn (async active-low), bus (master modport: requester
//           handshakes, engine command/ready/done, refresh_debt, overrun_err).
module sdram_request_scheduler
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int REFRESH_DEBT_MAX = DEF_REFRESH_DEBT_MAX,
    parameter int FORCE_LEVEL      = DEF_FORCE_LEVEL
) (
    input logic                       sdram_clk,
    input logic                       resetn,
    sdram_request_scheduler_if.master bus
);
    sched_state_e          state;
    cmd_op_e               last_grant;
    cmd_op_e               sel_op;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DEBT_WIDTH-1:0] debt;
    logic                  overrun;
    logic                  refresh_taken;

    // Debt is decremented on the acceptance edge itself, not when the ack would pulse.
    assign refresh_taken = (state == ST_ISSUE) && bus.cmd_valid && bus.cmd_ready
                           && (bus.cmd_op == CMD_REFRESH);

    assign bus.refresh_debt = debt;
    assign bus.overrun_err  = overrun;

    refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .REFRESH_DEBT_MAX (REFRESH_DEBT_MAX)
    ) u_refresh_timer (
        .sdram_clk     (sdram_clk),
        .resetn        (resetn),
        .refresh_taken (refresh_taken),
        .debt          (debt),
        .overrun       (overrun)
    );

    always_comb begin
        sel_op   = pick_source(debt >= DEBT_WIDTH'(FORCE_LEVEL), debt != '0,
                               bus.wr_req, bus.rd_req, bus.rd_urgent, last_grant);
        sel_addr = '0;
        if (sel_op == CMD_WRITE)
            sel_addr = bus.wr_addr;
        else if (sel_op == CMD_READ)
            sel_addr = bus.rd_addr;
    end

    always_ff @(posedge sdram_clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            last_grant    <= CMD_READ;
            bus.cmd_valid <= 1'b0;
            bus.cmd_op    <= CMD_NONE;
            bus.cmd_addr  <= '0;
            bus.wr_ack    <= 1'b0;
            bus.rd_ack    <= 1'b0;
        end else begin
            bus.wr_ack <= 1'b0;
            bus.rd_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_op != CMD_NONE) begin
                        bus.cmd_valid <= 1'b1;
                        bus.cmd_op    <= sel_op;
                        bus.cmd_addr  <= sel_addr;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // cmd_done here is meaningless and deliberately ignored.
                    if (bus.cmd_ready) begin
                        bus.cmd_valid <= 1'b0;
                        state         <= ST_BUSY;
                        if (bus.cmd_op == CMD_WRITE) begin
                            bus.wr_ack <= 1'b1;
                            last_grant <= CMD_WRITE;
                        end else if (bus.cmd_op == CMD_READ) begin
                            bus.rd_ack <= 1'b1;
                            last_grant <= CMD_READ;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.cmd_done) begin
                        bus.cmd_op   <= CMD_NONE;
                        bus.cmd_addr <= '0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
